ram_port_arbiter: RTL

Round-robin arbiter that shares one `param_single_port_ram` instance between `NUM_REQ` requesters. It sits directly in front of the RAM and drives the RAM's `we`/`addr`/`din` from the granted requester. It captures the RAM's asynchronous read data into a response register and returns it to the requester that issued the read, one cycle after the read is accepted.

---
 rtl/ram_port_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (combinational read) between
// NUM_REQ requesters; read data is registered and returned to the issuing requester.
module ram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_din,
  input  logic [DATA_WIDTH-1:0]         ram_dout
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW    = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [PTR_W-1:0] win_idx;
  logic [SW-1:0]    cand;
  logic             grant_any;
  logic             read_accept;

  // Priority search starting at ptr_reg, wrapping modulo NUM_REQ (not a power of two in general).
  always_comb begin
    grant_any = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_reg} + SW'(k);
      if (cand >= SW'(NUM_REQ)) begin
        cand = cand - SW'(NUM_REQ);
      end
      if (!grant_any && req_valid[cand[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
    // Nothing may be granted while reset is held, whatever the requesters present.
    if (rst) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    req_ready   = '0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_din     = '0;
    ptr_next    = ptr_reg;
    read_accept = 1'b0;
    if (grant_any) begin
      req_ready   = NUM_REQ'(1) << win_idx;
      ram_we      = req_we[win_idx];
      ram_addr    = addr_arr[win_idx];
      ram_din     = wdata_arr[win_idx];
      read_accept = ~req_we[win_idx];
      ptr_next    = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      ptr_reg <= ptr_next;
      if (read_accept) begin
        rsp_valid <= req_ready;
        rsp_rdata <= ram_dout;
      end else begin
        rsp_valid <= '0;
      end
    end
  end
endmodule
